// File: rtl/cache_bus_arbiter.sv
// rtl/cache_bus_arbiter.sv - round-robin snooping-bus arbiter and transaction sequencer
module cache_bus_arbiter #(
    parameter int Addr          = 37,
    parameter int SNOOP_TIMEOUT = 15
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            Bus_Req_1,
    input  logic            Bus_Req_2,
    input  logic [1:0]      Bus_Cmd_1,
    input  logic [1:0]      Bus_Cmd_2,
    input  logic [Addr-1:0] Bus_Addr_1,
    input  logic [Addr-1:0] Bus_Addr_2,
    input  logic            Snoop_Ack_1,
    input  logic            Snoop_Ack_2,
    input  logic            Snoop_Flush_1,
    input  logic            Snoop_Flush_2,
    input  logic            Mem_Done,
    output logic            Bus_Grant_1,
    output logic            Bus_Grant_2,
    output logic            Bus_Done_1,
    output logic            Bus_Done_2,
    output logic            Snoop_Valid_1,
    output logic            Snoop_Valid_2,
    output logic [1:0]      Snoop_Cmd,
    output logic [Addr-1:0] Snoop_Addr,
    output logic            Mem_Req,
    output logic            Mem_We,
    output logic [Addr-1:0] Mem_Addr,
    output logic            Last_Grant,
    output logic [15:0]     Txn_Count,
    output logic            Timeout_Err
);

    typedef enum logic [1:0] {IDLE, SNOOP, MEM, DONE} state_t;

    localparam logic [1:0] CMD_WB   = 2'b00;
    localparam logic [1:0] CMD_UPGR = 2'b11;
    localparam logic [7:0] WAIT_LAST = 8'(SNOOP_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              owner_q, owner_d;      // 0 = cache 1, 1 = cache 2
    logic [7:0]        wait_q, wait_d;

    logic              grant_1_d, grant_2_d, done_1_d, done_2_d;
    logic              valid_1_d, valid_2_d, mem_req_d, mem_we_d;
    logic [1:0]        snoop_cmd_d;
    logic [Addr-1:0]   snoop_addr_d, mem_addr_d;
    logic              last_grant_d, timeout_d;
    logic [15:0]       txn_count_d;

    logic              sel;
    logic [1:0]        sel_cmd;
    logic [Addr-1:0]   sel_addr;
    logic              ack, flush;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        wait_d       = wait_q;
        grant_1_d    = Bus_Grant_1;
        grant_2_d    = Bus_Grant_2;
        done_1_d     = 1'b0;
        done_2_d     = 1'b0;
        valid_1_d    = Snoop_Valid_1;
        valid_2_d    = Snoop_Valid_2;
        mem_req_d    = Mem_Req;
        mem_we_d     = Mem_We;
        snoop_cmd_d  = Snoop_Cmd;
        snoop_addr_d = Snoop_Addr;
        mem_addr_d   = Mem_Addr;
        last_grant_d = Last_Grant;
        timeout_d    = Timeout_Err;
        txn_count_d  = Txn_Count;

        // Tie goes to whichever cache was not served last.
        sel      = (Bus_Req_1 && Bus_Req_2) ? ~Last_Grant : Bus_Req_2;
        sel_cmd  = sel ? Bus_Cmd_2 : Bus_Cmd_1;
        sel_addr = sel ? Bus_Addr_2 : Bus_Addr_1;
        // Only the snooped (non-owning) cache may answer.
        ack      = owner_q ? Snoop_Ack_1 : Snoop_Ack_2;
        flush    = owner_q ? Snoop_Flush_1 : Snoop_Flush_2;

        unique case (state_q)
            IDLE: begin
                if (Bus_Req_1 || Bus_Req_2) begin
                    owner_d      = sel;
                    snoop_cmd_d  = sel_cmd;
                    snoop_addr_d = sel_addr;
                    mem_addr_d   = sel_addr;
                    grant_1_d    = ~sel;
                    grant_2_d    = sel;
                    wait_d       = 8'd0;
                    if (sel_cmd == CMD_WB) begin
                        state_d   = MEM;
                        mem_req_d = 1'b1;
                        mem_we_d  = 1'b1;
                    end else begin
                        state_d   = SNOOP;
                        valid_1_d = sel;
                        valid_2_d = ~sel;
                    end
                end
            end
            SNOOP: begin
                if (ack || wait_q == WAIT_LAST) begin
                    valid_1_d = 1'b0;
                    valid_2_d = 1'b0;
                    if (!ack) timeout_d = 1'b1;
                    if ((ack && flush) || Snoop_Cmd == CMD_UPGR) begin
                        state_d  = DONE;
                        done_1_d = ~owner_q;
                        done_2_d = owner_q;
                    end else begin
                        state_d   = MEM;
                        mem_req_d = 1'b1;
                        mem_we_d  = 1'b0;
                    end
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            MEM: begin
                if (Mem_Done) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    done_1_d  = ~owner_q;
                    done_2_d  = owner_q;
                end
            end
            DONE: begin
                state_d      = IDLE;
                grant_1_d    = 1'b0;
                grant_2_d    = 1'b0;
                valid_1_d    = 1'b0;
                valid_2_d    = 1'b0;
                mem_req_d    = 1'b0;
                mem_we_d     = 1'b0;
                last_grant_d = owner_q;
                txn_count_d  = (Txn_Count == 16'hFFFF) ? Txn_Count : Txn_Count + 16'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q       <= IDLE;
            owner_q       <= 1'b0;
            wait_q        <= 8'd0;
            Bus_Grant_1   <= 1'b0;
            Bus_Grant_2   <= 1'b0;
            Bus_Done_1    <= 1'b0;
            Bus_Done_2    <= 1'b0;
            Snoop_Valid_1 <= 1'b0;
            Snoop_Valid_2 <= 1'b0;
            Snoop_Cmd     <= 2'b00;
            Snoop_Addr    <= '0;
            Mem_Req       <= 1'b0;
            Mem_We        <= 1'b0;
            Mem_Addr      <= '0;
            Last_Grant    <= 1'b1;
            Txn_Count     <= 16'd0;
            Timeout_Err   <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            wait_q        <= wait_d;
            Bus_Grant_1   <= grant_1_d;
            Bus_Grant_2   <= grant_2_d;
            Bus_Done_1    <= done_1_d;
            Bus_Done_2    <= done_2_d;
            Snoop_Valid_1 <= valid_1_d;
            Snoop_Valid_2 <= valid_2_d;
            Snoop_Cmd     <= snoop_cmd_d;
            Snoop_Addr    <= snoop_addr_d;
            Mem_Req       <= mem_req_d;
            Mem_We        <= mem_we_d;
            Mem_Addr      <= mem_addr_d;
            Last_Grant    <= last_grant_d;
            Txn_Count     <= txn_count_d;
            Timeout_Err   <= timeout_d;
        end
    end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// tb/tb_cache_bus_arbiter.sv - directed self-checking bench for cache_bus_arbiter
module tb_cache_bus_arbiter;

    localparam int AW = 37;

    logic          CLK = 1'b0;
    logic          RST;
    logic          Bus_Req_1, Bus_Req_2;
    logic [1:0]    Bus_Cmd_1, Bus_Cmd_2;
    logic [AW-1:0] Bus_Addr_1, Bus_Addr_2;
    logic          Snoop_Ack_1, Snoop_Ack_2, Snoop_Flush_1, Snoop_Flush_2;
    logic          Mem_Done;
    logic          Bus_Grant_1, Bus_Grant_2, Bus_Done_1, Bus_Done_2;
    logic          Snoop_Valid_1, Snoop_Valid_2;
    logic [1:0]    Snoop_Cmd;
    logic [AW-1:0] Snoop_Addr, Mem_Addr;
    logic          Mem_Req, Mem_We, Last_Grant, Timeout_Err;
    logic [15:0]   Txn_Count;

    int checks = 0;
    int errors = 0;

    cache_bus_arbiter #(.Addr(AW), .SNOOP_TIMEOUT(15)) dut (
        .CLK(CLK), .RST(RST),
        .Bus_Req_1(Bus_Req_1), .Bus_Req_2(Bus_Req_2),
        .Bus_Cmd_1(Bus_Cmd_1), .Bus_Cmd_2(Bus_Cmd_2),
        .Bus_Addr_1(Bus_Addr_1), .Bus_Addr_2(Bus_Addr_2),
        .Snoop_Ack_1(Snoop_Ack_1), .Snoop_Ack_2(Snoop_Ack_2),
        .Snoop_Flush_1(Snoop_Flush_1), .Snoop_Flush_2(Snoop_Flush_2),
        .Mem_Done(Mem_Done),
        .Bus_Grant_1(Bus_Grant_1), .Bus_Grant_2(Bus_Grant_2),
        .Bus_Done_1(Bus_Done_1), .Bus_Done_2(Bus_Done_2),
        .Snoop_Valid_1(Snoop_Valid_1), .Snoop_Valid_2(Snoop_Valid_2),
        .Snoop_Cmd(Snoop_Cmd), .Snoop_Addr(Snoop_Addr),
        .Mem_Req(Mem_Req), .Mem_We(Mem_We), .Mem_Addr(Mem_Addr),
        .Last_Grant(Last_Grant), .Txn_Count(Txn_Count), .Timeout_Err(Timeout_Err)
    );

    always #5 CLK = ~CLK;

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        RST = 1'b0;
        cyc();
        cyc();
        RST = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        logic [7:0] outs;
        apply_reset();
        outs = {Bus_Grant_1, Bus_Grant_2, Bus_Done_1, Bus_Done_2,
                Snoop_Valid_1, Snoop_Valid_2, Mem_Req, Mem_We};
        checks++;
        if (outs !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000000", outs);
        end
        checks++;
        if (Last_Grant !== 1'b1) begin
            errors++;
            $display("FAIL reset_last_grant: got %b expected 1", Last_Grant);
        end
        checks++;
        if (Txn_Count !== 16'd0 || Timeout_Err !== 1'b0 || Snoop_Addr !== '0 || Mem_Addr !== '0 || Snoop_Cmd !== 2'b00) begin
            errors++;
            $display("FAIL reset_data: got cnt=%0h to=%b sa=%0h ma=%0h cmd=%0h expected all 0",
                     Txn_Count, Timeout_Err, Snoop_Addr, Mem_Addr, Snoop_Cmd);
        end
    endtask

    task automatic test_busrd_mem();
        logic [AW-1:0] a;
        int valid_cycles;
        a = 37'h0000001040;
        Bus_Req_1 = 1'b1; Bus_Cmd_1 = 2'b01; Bus_Addr_1 = a;
        cyc();
        Bus_Req_1 = 1'b0;
        checks++;
        if ({Bus_Grant_1, Bus_Grant_2, Snoop_Valid_1, Snoop_Valid_2} !== 4'b1001) begin
            errors++;
            $display("FAIL rd_grant: got g1g2v1v2=%b expected 1001",
                     {Bus_Grant_1, Bus_Grant_2, Snoop_Valid_1, Snoop_Valid_2});
        end
        checks++;
        if (Snoop_Cmd !== 2'b01 || Snoop_Addr !== a || Mem_Addr !== a || Mem_Req !== 1'b0) begin
            errors++;
            $display("FAIL rd_latch: got cmd=%0h sa=%0h ma=%0h mreq=%b expected 1 %0h %0h 0",
                     Snoop_Cmd, Snoop_Addr, Mem_Addr, Mem_Req, a, a);
        end
        valid_cycles = 1;
        cyc();
        if (Snoop_Valid_2) valid_cycles++;
        cyc();
        if (Snoop_Valid_2) valid_cycles++;
        Snoop_Ack_2 = 1'b1; Snoop_Flush_2 = 1'b0;
        cyc();
        Snoop_Ack_2 = 1'b0;
        if (Snoop_Valid_2) valid_cycles++;
        checks++;
        if (valid_cycles !== 3) begin
            errors++;
            $display("FAIL rd_valid_len: got %0d cycles expected 3", valid_cycles);
        end
        checks++;
        if (Mem_Req !== 1'b1 || Mem_We !== 1'b0 || Bus_Done_1 !== 1'b0) begin
            errors++;
            $display("FAIL rd_mem: got req=%b we=%b done=%b expected 1 0 0", Mem_Req, Mem_We, Bus_Done_1);
        end
        cyc();
        cyc();
        Mem_Done = 1'b1;
        checks++;
        if (Mem_Req !== 1'b1 || Bus_Done_1 !== 1'b0) begin
            errors++;
            $display("FAIL rd_mem_hold: got req=%b done=%b expected 1 0", Mem_Req, Bus_Done_1);
        end
        cyc();
        Mem_Done = 1'b0;
        checks++;
        if (Bus_Done_1 !== 1'b1 || Bus_Done_2 !== 1'b0 || Bus_Grant_1 !== 1'b1) begin
            errors++;
            $display("FAIL rd_done: got d1=%b d2=%b g1=%b expected 1 0 1", Bus_Done_1, Bus_Done_2, Bus_Grant_1);
        end
        cyc();
        checks++;
        if (Bus_Done_1 !== 1'b0 || Bus_Grant_1 !== 1'b0 || Txn_Count !== 16'd1 || Last_Grant !== 1'b0) begin
            errors++;
            $display("FAIL rd_after: got d1=%b g1=%b cnt=%0d lg=%b expected 0 0 1 0",
                     Bus_Done_1, Bus_Grant_1, Txn_Count, Last_Grant);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] seq;
        int n;
        logic both, mem_seen;
        apply_reset();
        seq = 4'b0000; n = 0; both = 1'b0; mem_seen = 1'b0;
        Bus_Req_1 = 1'b1; Bus_Cmd_1 = 2'b10; Bus_Addr_1 = 37'h00000000A0;
        Bus_Req_2 = 1'b1; Bus_Cmd_2 = 2'b10; Bus_Addr_2 = 37'h1F000000B0;
        Snoop_Flush_1 = 1'b1; Snoop_Flush_2 = 1'b1;
        for (int c = 0; c < 40 && n < 4; c++) begin
            cyc();
            if (Bus_Grant_1 && Bus_Grant_2) both = 1'b1;
            if (Mem_Req) mem_seen = 1'b1;
            if (Bus_Done_1 || Bus_Done_2) begin
                seq[n] = Bus_Done_2;
                n++;
            end
            Snoop_Ack_1 = Snoop_Valid_1;
            Snoop_Ack_2 = Snoop_Valid_2;
        end
        Bus_Req_1 = 1'b0; Bus_Req_2 = 1'b0;
        Snoop_Ack_1 = 1'b0; Snoop_Ack_2 = 1'b0;
        Snoop_Flush_1 = 1'b0; Snoop_Flush_2 = 1'b0;
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL rr_count: got %0d done pulses expected 4", n);
        end
        checks++;
        if (seq !== 4'b1010) begin
            errors++;
            $display("FAIL rr_order: got owners(lsb first)=%b expected 1010", seq);
        end
        checks++;
        if (both !== 1'b0 || mem_seen !== 1'b0) begin
            errors++;
            $display("FAIL rr_excl: got both_grants=%b mem_req_seen=%b expected 0 0", both, mem_seen);
        end
        cyc();
        cyc();
        checks++;
        if (Txn_Count !== 16'd4 || Last_Grant !== 1'b1) begin
            errors++;
            $display("FAIL rr_txn: got cnt=%0d lg=%b expected 4 1", Txn_Count, Last_Grant);
        end
    endtask

    task automatic test_timeout_upgr();
        int valid_cycles, done_cnt, d1_cnt;
        logic mem_seen, to_at_done;
        valid_cycles = 0; done_cnt = 0; d1_cnt = 0; mem_seen = 1'b0; to_at_done = 1'b0;
        Bus_Req_2 = 1'b1; Bus_Cmd_2 = 2'b11; Bus_Addr_2 = 37'h0123456789;
        cyc();
        Bus_Req_2 = 1'b0;
        checks++;
        if (Bus_Grant_2 !== 1'b1 || Snoop_Valid_1 !== 1'b1 || Snoop_Valid_2 !== 1'b0 || Timeout_Err !== 1'b0) begin
            errors++;
            $display("FAIL to_grant: got g2=%b v1=%b v2=%b to=%b expected 1 1 0 0",
                     Bus_Grant_2, Snoop_Valid_1, Snoop_Valid_2, Timeout_Err);
        end
        for (int c = 0; c < 25; c++) begin
            if (Snoop_Valid_1) valid_cycles++;
            if (Mem_Req) mem_seen = 1'b1;
            if (Bus_Done_1) d1_cnt++;
            if (Bus_Done_2) begin
                done_cnt++;
                to_at_done = Timeout_Err;
            end
            cyc();
        end
        checks++;
        if (valid_cycles !== 15) begin
            errors++;
            $display("FAIL to_snoop_len: got %0d cycles expected 15", valid_cycles);
        end
        checks++;
        if (done_cnt !== 1 || d1_cnt !== 0 || mem_seen !== 1'b0) begin
            errors++;
            $display("FAIL to_done: got d2=%0d d1=%0d mem_seen=%b expected 1 0 0", done_cnt, d1_cnt, mem_seen);
        end
        checks++;
        if (to_at_done !== 1'b1 || Timeout_Err !== 1'b1) begin
            errors++;
            $display("FAIL to_flag: got at_done=%b now=%b expected 1 1", to_at_done, Timeout_Err);
        end
        checks++;
        if (Txn_Count !== 16'd5 || Last_Grant !== 1'b1) begin
            errors++;
            $display("FAIL to_txn: got cnt=%0d lg=%b expected 5 1", Txn_Count, Last_Grant);
        end
    endtask

    task automatic test_ack_at_timeout();
        apply_reset();
        Bus_Req_1 = 1'b1; Bus_Cmd_1 = 2'b11; Bus_Addr_1 = 37'h0000000FC0;
        Snoop_Ack_1 = 1'b1;
        cyc();
        Bus_Req_1 = 1'b0;
        for (int k = 1; k < 15; k++) cyc();
        checks++;
        if (Snoop_Valid_2 !== 1'b1 || Bus_Done_1 !== 1'b0) begin
            errors++;
            $display("FAIL edge_still_snoop: got v2=%b d1=%b expected 1 0", Snoop_Valid_2, Bus_Done_1);
        end
        Snoop_Ack_2 = 1'b1; Snoop_Flush_2 = 1'b0;
        cyc();
        Snoop_Ack_2 = 1'b0; Snoop_Ack_1 = 1'b0;
        checks++;
        if (Bus_Done_1 !== 1'b1 || Timeout_Err !== 1'b0 || Mem_Req !== 1'b0) begin
            errors++;
            $display("FAIL edge_ack_wins: got d1=%b to=%b mreq=%b expected 1 0 0", Bus_Done_1, Timeout_Err, Mem_Req);
        end
        cyc();
    endtask

    task automatic test_buswb_reset();
        logic [AW-1:0] a;
        int done_cnt;
        a = 37'h1ABCDEF000;
        done_cnt = 0;
        Bus_Req_2 = 1'b1; Bus_Cmd_2 = 2'b00; Bus_Addr_2 = a;
        cyc();
        Bus_Req_2 = 1'b0;
        checks++;
        if ({Bus_Grant_2, Mem_Req, Mem_We, Snoop_Valid_1, Snoop_Valid_2} !== 5'b11100 || Mem_Addr !== a) begin
            errors++;
            $display("FAIL wb_start: got g2/req/we/v1/v2=%b ma=%0h expected 11100 %0h",
                     {Bus_Grant_2, Mem_Req, Mem_We, Snoop_Valid_1, Snoop_Valid_2}, Mem_Addr, a);
        end
        cyc();
        cyc();
        RST = 1'b0;
        #1;
        checks++;
        if ({Bus_Grant_2, Mem_Req, Mem_We} !== 3'b000 || Last_Grant !== 1'b1 || Txn_Count !== 16'd0) begin
            errors++;
            $display("FAIL wb_reset: got g2/req/we=%b lg=%b cnt=%0d expected 000 1 0",
                     {Bus_Grant_2, Mem_Req, Mem_We}, Last_Grant, Txn_Count);
        end
        cyc();
        RST = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cyc();
            if (Bus_Done_1 || Bus_Done_2 || Bus_Grant_1 || Bus_Grant_2) done_cnt++;
        end
        checks++;
        if (done_cnt !== 0) begin
            errors++;
            $display("FAIL wb_no_done: got %0d active cycles expected 0", done_cnt);
        end
        Bus_Req_1 = 1'b1; Bus_Cmd_1 = 2'b00; Bus_Addr_1 = 37'h0000000040;
        cyc();
        Bus_Req_1 = 1'b0;
        Mem_Done = 1'b1;
        cyc();
        Mem_Done = 1'b0;
        checks++;
        if (Bus_Done_1 !== 1'b1 || Bus_Done_2 !== 1'b0) begin
            errors++;
            $display("FAIL wb_after_done: got d1=%b d2=%b expected 1 0", Bus_Done_1, Bus_Done_2);
        end
        cyc();
        checks++;
        if (Txn_Count !== 16'd1 || Last_Grant !== 1'b0 || Bus_Grant_1 !== 1'b0) begin
            errors++;
            $display("FAIL wb_after_txn: got cnt=%0d lg=%b g1=%b expected 1 0 0", Txn_Count, Last_Grant, Bus_Grant_1);
        end
    endtask

    initial begin
        RST = 1'b0;
        Bus_Req_1 = 1'b0; Bus_Req_2 = 1'b0;
        Bus_Cmd_1 = 2'b00; Bus_Cmd_2 = 2'b00;
        Bus_Addr_1 = '0; Bus_Addr_2 = '0;
        Snoop_Ack_1 = 1'b0; Snoop_Ack_2 = 1'b0;
        Snoop_Flush_1 = 1'b0; Snoop_Flush_2 = 1'b0;
        Mem_Done = 1'b0;
        test_reset();
        test_busrd_mem();
        test_round_robin();
        test_timeout_upgr();
        test_ack_at_timeout();
        test_buswb_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
